// File: rtl/toggle_sequencer.sv
// Issues a programmed number of one-cycle t pulses, separated by idle gaps, then a done pulse.
// Optional abort input is enabled by defining TOGGLE_SEQ_ABORT_EN.
module toggle_sequencer #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_toggles,
    input  logic [GAP_W-1:0] gap,
`ifdef TOGGLE_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap_lat;
    logic [GAP_W-1:0]   gap_cnt;
    logic               abort_act;

`ifdef TOGGLE_SEQ_ABORT_EN
    assign abort_act = abort && (state == PULSE || state == GAP);
`else
    assign abort_act = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_toggles == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (abort_act || cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end else if (gap_lat != '0) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (abort_act) begin
                    state_nxt = DONE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = PULSE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state register by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            t         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            t         <= (state == PULSE) && !abort_act;
            busy      <= (state != IDLE);
            done      <= (state == DONE);
            remaining <= cnt;

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= num_toggles;
                        gap_lat <= gap;
                    end
                end
                PULSE: begin
                    if (!abort_act && cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    if (state_nxt == GAP) begin
                        gap_cnt <= gap_lat;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
